// File: rtl/inst_fetch_pipe.sv
// Fetch stage between icache and decode: block-aligned requests with one outstanding,
// slot masking/truncation from the branch predictor, and an internal packet queue.
module inst_fetch_pipe #(
    parameter int          FETCH_WIDTH = 4,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] RESET_PC    = 32'h1000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             redirect_valid,
    input  logic [31:0]                      redirect_pc,
    output logic [31:0]                      bp_pc,
    input  logic [FETCH_WIDTH-1:0]           bp_taken,
    input  logic [31:0]                      bp_target,
    output logic                             core2icache_req_valid,
    input  logic                             core2icache_req_ready,
    output logic [31:0]                      core2icache_addr,
    input  logic [32*FETCH_WIDTH-1:0]        icache2core_data,
    input  logic                             icache2core_data_valid,
    output logic                             fq_out_valid,
    input  logic                             fq_out_ready,
    output logic [32*FETCH_WIDTH-1:0]        fq_out_inst,
    output logic [31:0]                      fq_out_pc,
    output logic [FETCH_WIDTH-1:0]           fq_out_slot_valid,
    output logic [FETCH_WIDTH-1:0]           fq_out_pred_taken,
    output logic [31:0]                      fq_out_pred_target,
    output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count
);
    localparam int          B           = $clog2(FETCH_WIDTH*4);
    localparam int          OW          = $clog2(FETCH_WIDTH);
    localparam int          PW          = $clog2(FQ_DEPTH);
    localparam int          CW          = $clog2(FQ_DEPTH+1);
    localparam logic [31:0] BLOCK_BYTES = 32'(FETCH_WIDTH*4);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       req_pc_reg;
    logic [PW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg;

    logic [32*FETCH_WIDTH-1:0] inst_mem   [FQ_DEPTH];
    logic [31:0]               pc_mem     [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0]    slot_mem   [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0]    taken_mem  [FQ_DEPTH];
    logic [31:0]               target_mem [FQ_DEPTH];

    logic                   req_fire, push, pop;
    logic [31:0]            req_aligned;
    logic [OW-1:0]          req_off;
    logic [FETCH_WIDTH-1:0] raw_valid;
    logic [FETCH_WIDTH-1:0] pkt_slot_valid, pkt_pred_taken;
    logic                   pkt_any_taken;
    logic [31:0]            pkt_next_pc, pkt_target;

    assign core2icache_addr = {pc_reg[31:B], {B{1'b0}}};
    assign bp_pc            = req_pc_reg;
    assign req_aligned      = {req_pc_reg[31:B], {B{1'b0}}};
    assign req_off          = req_pc_reg[B-1:2];

    assign core2icache_req_valid = !reset && (state_reg == ST_REQ) && !redirect_valid
                                   && (count_reg < CW'(FQ_DEPTH));
    assign req_fire = core2icache_req_valid && core2icache_req_ready;
    assign push     = (state_reg == ST_WAIT) && icache2core_data_valid && !redirect_valid;
    assign pop      = fq_out_valid && fq_out_ready;

    // Slots before the request offset belong to an earlier fetch target.
    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_raw_valid
            assign raw_valid[gi] = (OW'(gi) >= req_off);
        end
    endgenerate

    // Keep slots up to and including the first predicted-taken valid slot.
    always_comb begin
        pkt_slot_valid = '0;
        pkt_any_taken  = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (raw_valid[i] && !pkt_any_taken) begin
                pkt_slot_valid[i] = 1'b1;
            end
            if (raw_valid[i] && bp_taken[i]) begin
                pkt_any_taken = 1'b1;
            end
        end
    end

    assign pkt_pred_taken = bp_taken & pkt_slot_valid;
    assign pkt_next_pc    = pkt_any_taken ? bp_target : req_aligned + BLOCK_BYTES;
    assign pkt_target     = pkt_any_taken ? bp_target : 32'd0;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_REQ: begin
                if (req_fire) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (icache2core_data_valid) state_next = ST_REQ;
                else if (redirect_valid)    state_next = ST_DROP;
            end
            ST_DROP: begin
                if (icache2core_data_valid) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
    end

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) pc_next = redirect_pc;
        else if (push)      pc_next = pkt_next_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_REQ;
            pc_reg     <= RESET_PC;
            req_pc_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (req_fire) req_pc_reg <= pc_reg;
        end
    end

    // A flush overrides any same-cycle pop; the popped packet was still delivered.
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + PW'(1);
            if (pop)  head_reg <= head_reg + PW'(1);
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[tail_reg]   <= icache2core_data;
            pc_mem[tail_reg]     <= req_aligned;
            slot_mem[tail_reg]   <= pkt_slot_valid;
            taken_mem[tail_reg]  <= pkt_pred_taken;
            target_mem[tail_reg] <= pkt_target;
        end
    end

    assign fq_out_valid       = !reset && (count_reg != '0);
    assign fq_out_inst        = inst_mem[head_reg];
    assign fq_out_pc          = pc_mem[head_reg];
    assign fq_out_slot_valid  = slot_mem[head_reg];
    assign fq_out_pred_taken  = taken_mem[head_reg];
    assign fq_out_pred_target = target_mem[head_reg];
    assign fq_count           = count_reg;

endmodule

// File: tb/tb_inst_fetch_pipe.sv
// Self-checking bench for inst_fetch_pipe: behavioural icache/predictor plus a
// packet-queue reference model, directed scenarios followed by random traffic.
module tb_inst_fetch_pipe;
    localparam int          FW  = 4;
    localparam int          FQD = 4;
    localparam logic [31:0] RPC = 32'h1000;
    localparam int          CW  = $clog2(FQD+1);

    logic                clock = 1'b0;
    logic                reset;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [31:0]         bp_pc;
    logic [FW-1:0]       bp_taken;
    logic [31:0]         bp_target;
    logic                core2icache_req_valid;
    logic                core2icache_req_ready;
    logic [31:0]         core2icache_addr;
    logic [32*FW-1:0]    icache2core_data;
    logic                icache2core_data_valid;
    logic                fq_out_valid;
    logic                fq_out_ready;
    logic [32*FW-1:0]    fq_out_inst;
    logic [31:0]         fq_out_pc;
    logic [FW-1:0]       fq_out_slot_valid;
    logic [FW-1:0]       fq_out_pred_taken;
    logic [31:0]         fq_out_pred_target;
    logic [CW-1:0]       fq_count;

    always #5 clock = ~clock;

    inst_fetch_pipe #(
        .FETCH_WIDTH (FW),
        .FQ_DEPTH    (FQD),
        .RESET_PC    (RPC)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .bp_pc                  (bp_pc),
        .bp_taken               (bp_taken),
        .bp_target              (bp_target),
        .core2icache_req_valid  (core2icache_req_valid),
        .core2icache_req_ready  (core2icache_req_ready),
        .core2icache_addr       (core2icache_addr),
        .icache2core_data       (icache2core_data),
        .icache2core_data_valid (icache2core_data_valid),
        .fq_out_valid           (fq_out_valid),
        .fq_out_ready           (fq_out_ready),
        .fq_out_inst            (fq_out_inst),
        .fq_out_pc              (fq_out_pc),
        .fq_out_slot_valid      (fq_out_slot_valid),
        .fq_out_pred_taken      (fq_out_pred_taken),
        .fq_out_pred_target     (fq_out_pred_target),
        .fq_count               (fq_count)
    );

    typedef struct packed {
        logic [32*FW-1:0] inst;
        logic [31:0]      pc;
        logic [FW-1:0]    sv;
        logic [FW-1:0]    pt;
        logic [31:0]      tgt;
    } pkt_t;

    pkt_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_inflight;
    bit          m_drop;
    int          resp_wait;
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Slot list starts at the PC's word offset and ends at the first taken slot.
    function automatic pkt_t form_pkt(input logic [31:0] pc, input logic [32*FW-1:0] d,
                                      input logic [FW-1:0] tk, input logic [31:0] tg,
                                      output logic [31:0] npc);
        pkt_t p;
        int   off;
        bit   hit;
        off   = int'((pc / 4) % FW);
        hit   = 0;
        p.inst = d;
        p.pc   = pc - (pc % (FW*4));
        p.sv   = '0;
        p.pt   = '0;
        p.tgt  = '0;
        for (int i = off; i < FW && !hit; i++) begin
            p.sv[i] = 1'b1;
            if (tk[i]) begin
                p.pt[i] = 1'b1;
                hit     = 1;
            end
        end
        if (hit) begin
            p.tgt = tg;
            npc   = tg;
        end else begin
            npc = p.pc + 32'(FW*4);
        end
        return p;
    endfunction

    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input bit frdy, input int lat,
                        input logic [FW-1:0] tk, input logic [31:0] tg);
        bit               dv, exp_rv, pop, hs;
        logic [32*FW-1:0] dat;
        logic [31:0]      npc;
        pkt_t             p;
        @(negedge clock);
        dv = 0;
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) dv = 1;
        end
        if (rst) begin
            dv        = 0;
            resp_wait = 0;
        end
        for (int i = 0; i < FW; i++) dat[32*i +: 32] = $urandom();
        reset                  = rst;
        redirect_valid         = redir;
        redirect_pc            = rpc;
        core2icache_req_ready  = rdy;
        fq_out_ready           = frdy;
        icache2core_data_valid = dv;
        icache2core_data       = dat;
        bp_taken               = tk;
        bp_target              = tg;
        #1;
        exp_rv = !rst && !m_inflight && !redir && (mq.size() < FQD);
        check_val("req_valid", core2icache_req_valid, exp_rv);
        if (exp_rv) check_val("req_addr", core2icache_addr, m_pc - (m_pc % (FW*4)));
        check_val("fq_out_valid", fq_out_valid, !rst && mq.size() > 0);
        if (!rst) begin
            check_val("fq_count", fq_count, mq.size());
            if (mq.size() > 0) begin
                check_val("fq_out_inst", fq_out_inst, mq[0].inst);
                check_val("fq_out_pc", fq_out_pc, mq[0].pc);
                check_val("fq_out_slot_valid", fq_out_slot_valid, mq[0].sv);
                check_val("fq_out_pred_taken", fq_out_pred_taken, mq[0].pt);
                check_val("fq_out_pred_target", fq_out_pred_target, mq[0].tgt);
            end
            if (dv && m_inflight && !m_drop) check_val("bp_pc", bp_pc, m_req_pc);
        end
        if (rst) begin
            mq.delete();
            m_pc       = RPC;
            m_inflight = 0;
            m_drop     = 0;
        end else begin
            pop = (mq.size() > 0) && frdy;
            hs  = exp_rv && rdy;
            if (pop) begin
                $display("pop pc=%h slots=%b taken=%b target=%h", mq[0].pc, mq[0].sv, mq[0].pt, mq[0].tgt);
                void'(mq.pop_front());
            end
            if (dv) begin
                if (!m_drop && !redir) begin
                    p = form_pkt(m_req_pc, dat, tk, tg, npc);
                    mq.push_back(p);
                    m_pc = npc;
                end
                m_inflight = 0;
                m_drop     = 0;
            end
            if (hs) begin
                m_inflight = 1;
                m_req_pc   = m_pc;
                resp_wait  = lat;
            end
            if (redir) begin
                mq.delete();
                m_pc = rpc;
                if (m_inflight && !dv) m_drop = 1;
            end
        end
    endtask

    bit          r_rst, r_red, r_rdy, r_frdy;
    logic [31:0] r_rpc, r_tg;
    logic [FW-1:0] r_tk;
    int          r_lat;

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        core2icache_req_ready = 1'b0; fq_out_ready = 1'b0;
        icache2core_data = '0; icache2core_data_valid = 1'b0;
        bp_taken = '0; bp_target = '0;
        m_pc = RPC; m_req_pc = RPC; m_inflight = 0; m_drop = 0; resp_wait = 0;

        repeat (3) step(1, 0, 0, 1, 1, 1, '0, '0);
        // sequential fetch
        repeat (10) step(0, 0, 0, 1, 1, 1, '0, '0);
        // unaligned redirect; taken bit on a masked slot
        step(0, 1, 32'h1008, 1, 1, 1, '0, '0);
        repeat (6) step(0, 0, 0, 1, 1, 1, 4'b0001, 32'h5000);
        // taken branch
        step(0, 1, 32'h1000, 1, 1, 1, '0, '0);
        repeat (2) step(0, 0, 0, 1, 1, 1, 4'b0110, 32'h2004);
        repeat (4) step(0, 0, 0, 1, 1, 1, 4'b0000, 32'h0);
        // backpressure: fill, one pop, refill
        repeat (14) step(0, 0, 0, 1, 0, 1, '0, '0);
        step(0, 0, 0, 1, 1, 1, '0, '0);
        repeat (5) step(0, 0, 0, 1, 0, 1, '0, '0);
        repeat (8) step(0, 0, 0, 0, 1, 1, '0, '0);
        // redirect while waiting on a 3-cycle icache
        step(0, 0, 0, 1, 1, 3, '0, '0);
        step(0, 1, 32'h3000, 1, 1, 3, '0, '0);
        repeat (6) step(0, 0, 0, 1, 1, 3, '0, '0);
        // redirect coincident with the response
        repeat (4) step(0, 0, 0, 0, 1, 2, '0, '0);
        step(0, 0, 0, 1, 1, 2, '0, '0);
        step(0, 0, 0, 1, 1, 2, '0, '0);
        step(0, 1, 32'h4000, 1, 1, 2, '0, '0);
        repeat (4) step(0, 0, 0, 1, 1, 1, '0, '0);
        // reset while waiting with packets queued
        repeat (12) step(0, 0, 0, 1, 0, 3, '0, '0);
        step(1, 0, 0, 1, 0, 3, '0, '0);
        repeat (4) step(0, 0, 0, 1, 1, 1, '0, '0);
        // wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFF4, 1, 1, 1, '0, '0);
        repeat (6) step(0, 0, 0, 1, 1, 1, '0, '0);

        for (int n = 0; n < 3000; n++) begin
            r_rst  = ($urandom_range(0, 199) == 0);
            r_red  = ($urandom_range(0, 19) == 0);
            r_rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                                 : (32'h1000 + 32'($urandom_range(0, 255) * 4));
            r_rdy  = ($urandom_range(0, 9) < 7);
            r_frdy = ($urandom_range(0, 9) < 6);
            r_lat  = $urandom_range(1, 4);
            r_tk   = ($urandom_range(0, 1) == 0) ? FW'($urandom()) : '0;
            r_tg   = $urandom() & ~32'h3;
            step(r_rst, r_red, r_rpc, r_rdy, r_frdy, r_lat, r_tk, r_tg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
